// File: rtl/flash_boot_loader.sv
// Boot-time SPI flash copier. Holds the CPU in reset, issues READ (0x03) with
// a 24-bit address to a mode-0 SPI flash, streams BYTE_COUNT bytes out over a
// valid/ready write port, then releases the CPU. Runs once per reset.
module flash_boot_loader #(
  parameter int unsigned BYTE_COUNT = 256,
  parameter logic [23:0] FLASH_ADDR = 24'h000000,
  parameter logic [18:0] DEST_ADDR  = 19'h7FF00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flash_miso_i,
  output logic        flash_cs_n_o,
  output logic        flash_sck_o,
  output logic        flash_mosi_o,
  output logic        wr_en_o,
  input  logic        wr_ready_i,
  output logic [18:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        cpu_reset_o,
  output logic        done_o
);

  localparam int unsigned     IdxW     = $clog2(BYTE_COUNT + 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(BYTE_COUNT - 1);
  // Command and address go out back to back as one 32-bit word.
  localparam logic [31:0]     TxWord   = {8'h03, FLASH_ADDR};
  // Each SPI bit spans two clocks, so these are (bits * 2) - 1.
  localparam logic [5:0]      CmdLast  = 6'd15;
  localparam logic [5:0]      AddrLast = 6'd47;
  localparam logic [5:0]      DataLast = 6'd15;

  typedef enum logic [2:0] {
    StStart,
    StCmd,
    StAddr,
    StData,
    StWrite,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      tick_q, tick_d;
  logic [31:0]     tx_q, tx_d;
  // Only the first seven bits of a byte are stored; the eighth comes
  // straight from MISO on the edge that moves to WRITE.
  logic [6:0]      rx_q, rx_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic            cs_n_q, cs_n_d;
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;
  logic            wr_en_q, wr_en_d;
  logic [18:0]     wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            cpu_reset_q, cpu_reset_d;
  logic            done_q, done_d;

  // Sequencer next state: tick counts clocks inside a shift state, odd ticks
  // are the SCK-high phase and their closing edge shifts TX / samples RX.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    idx_d   = idx_q;
    case (state_q)
      StStart: begin
        state_d = StCmd;
        tick_d  = '0;
      end
      StCmd: begin
        tick_d = tick_q + 6'd1;
        if (tick_q[0]) begin
          tx_d = {tx_q[30:0], 1'b0};
        end
        if (tick_q == CmdLast) begin
          state_d = StAddr;
          tick_d  = '0;
        end
      end
      StAddr: begin
        tick_d = tick_q + 6'd1;
        if (tick_q[0]) begin
          tx_d = {tx_q[30:0], 1'b0};
        end
        if (tick_q == AddrLast) begin
          state_d = StData;
          tick_d  = '0;
        end
      end
      StData: begin
        tick_d = tick_q + 6'd1;
        if (tick_q[0]) begin
          rx_d = {rx_q[5:0], flash_miso_i};
        end
        if (tick_q == DataLast) begin
          state_d = StWrite;
          tick_d  = '0;
        end
      end
      StWrite: begin
        // SCK stays low here, stretching the SPI transfer until accepted.
        if (wr_ready_i) begin
          idx_d = idx_q + IdxW'(1);
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            state_d = StData;
          end
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StStart;
        tick_d  = '0;
      end
    endcase
  end

  // Output next values are decoded from the next state so every pin is a
  // plain flop and changes exactly on the edge that enters the state.
  always_comb begin
    cs_n_d      = (state_d == StStart) || (state_d == StDone);
    sck_d       = (state_d inside {StCmd, StAddr, StData}) && tick_d[0];
    mosi_d      = (state_d inside {StCmd, StAddr}) && tx_d[31];
    wr_en_d     = (state_d == StWrite);
    cpu_reset_d = (state_d != StDone);
    done_d      = (state_d == StDone);
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    if ((state_q == StData) && (state_d == StWrite)) begin
      wr_data_d = {rx_q, flash_miso_i};
      // Natural 19-bit wrap gives the required modulo addressing.
      wr_addr_d = DEST_ADDR + 19'(idx_q);
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StStart;
      tick_q  <= '0;
      tx_q    <= TxWord;
      rx_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      idx_q   <= idx_d;
    end
  end

  // Registered outputs; reset drops the flash select and re-holds the CPU.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
    end
  end

  assign flash_cs_n_o = cs_n_q;
  assign flash_sck_o  = sck_q;
  assign flash_mosi_o = mosi_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign cpu_reset_o  = cpu_reset_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_flash_boot_loader.sv
// Bench for flash_boot_loader: three instances (4 bytes default, 4 bytes with
// wrapping destination, 1 byte from 0x012345) each talking to a small mode-0
// SPI flash model that answers READ from a 16-byte image.
module tb_flash_boot_loader;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic ready = 1'b1;

  logic        cs_n      [3];
  logic        sck       [3];
  logic        mosi      [3];
  logic        wr_en     [3];
  logic [18:0] wr_addr   [3];
  logic [7:0]  wr_data   [3];
  logic        cpu_reset [3];
  logic        done      [3];

  logic [7:0] mem [16] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h11, 8'h5A, 8'h22, 8'h33,
                           8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB};

  int pass_cnt  = 0;
  int total_cnt = 0;

  int          cap_n         [3];
  int          cap_cyc       [3][8];
  logic [18:0] cap_addr      [3][8];
  logic [7:0]  cap_data      [3][8];
  int          cap_len       [3][8];
  int          done_cyc      [3];
  logic        cpu_at_done   [3];
  logic        cs_at_done    [3];
  int          sck_wr        [3];
  int          unstable      [3];
  int          cs_after_done [3];
  logic        prev_wr       [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Bc  = (g == 2) ? 1 : 4;
    localparam logic [18:0] Dst = (g == 1) ? 19'h7FFFE : 19'h7FF00;
    localparam logic [23:0] Fa  = (g == 2) ? 24'h012345 : 24'h000000;

    logic        miso     = 1'b0;
    logic [31:0] sh       = '0;
    logic [31:0] cmd_last = '0;
    int          bits     = 0;
    int          dbit     = 0;
    int          boff     = 0;
    int          cmd_cnt  = 0;
    logic [3:0]  midx;
    logic [7:0]  cur;

    flash_boot_loader #(
      .BYTE_COUNT(Bc),
      .FLASH_ADDR(Fa),
      .DEST_ADDR (Dst)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flash_miso_i(miso),
      .flash_cs_n_o(cs_n[g]),
      .flash_sck_o (sck[g]),
      .flash_mosi_o(mosi[g]),
      .wr_en_o     (wr_en[g]),
      .wr_ready_i  (ready),
      .wr_addr_o   (wr_addr[g]),
      .wr_data_o   (wr_data[g]),
      .cpu_reset_o (cpu_reset[g]),
      .done_o      (done[g])
    );

    // Flash model: latch 32 command/address bits on rising SCK, then shift
    // data out MSB first on each falling SCK; deselect aborts the read.
    always @(posedge sck[g] or negedge sck[g] or posedge cs_n[g]) begin
      if (cs_n[g] === 1'b1) begin
        bits = 0;
        dbit = 0;
        boff = 0;
        miso = 1'b0;
      end else if (sck[g] === 1'b1) begin
        if (bits < 32) begin
          sh = {sh[30:0], mosi[g]};
          bits++;
          if (bits == 32) begin
            cmd_last = sh;
            cmd_cnt++;
          end
        end
      end else if (bits == 32) begin
        midx = sh[3:0] + 4'(boff);
        cur  = mem[midx];
        miso = cur[3'(7 - dbit)];
        dbit++;
        if (dbit == 8) begin
          dbit = 0;
          boff++;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs ncyc clocks after reset release, logging write pulses per instance.
  task automatic run_capture(input int ncyc, input int stall_from, input int stall_to);
    int k;
    for (int g = 0; g < 3; g++) begin
      cap_n[g]         = 0;
      done_cyc[g]      = 0;
      cpu_at_done[g]   = 1'b1;
      cs_at_done[g]    = 1'b0;
      sck_wr[g]        = 0;
      unstable[g]      = 0;
      cs_after_done[g] = 0;
      prev_wr[g]       = 1'b0;
      for (int j = 0; j < 8; j++) begin
        cap_cyc[g][j]  = 0;
        cap_addr[g][j] = '0;
        cap_data[g][j] = '0;
        cap_len[g][j]  = 0;
      end
    end
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
        if (wr_en[g] === 1'b1) begin
          if (!prev_wr[g]) begin
            if (cap_n[g] < 8) begin
              cap_cyc[g][cap_n[g]]  = n;
              cap_addr[g][cap_n[g]] = wr_addr[g];
              cap_data[g][cap_n[g]] = wr_data[g];
            end
            cap_n[g]++;
          end
          k = cap_n[g] - 1;
          if (k < 8) begin
            cap_len[g][k]++;
            if (wr_addr[g] !== cap_addr[g][k] || wr_data[g] !== cap_data[g][k]) unstable[g]++;
          end
          if (sck[g] !== 1'b0) sck_wr[g]++;
        end
        prev_wr[g] = (wr_en[g] === 1'b1);
        if (done[g] === 1'b1 && done_cyc[g] == 0) begin
          done_cyc[g]    = n;
          cpu_at_done[g] = cpu_reset[g];
          cs_at_done[g]  = cs_n[g];
        end
        if (done_cyc[g] != 0 && cs_n[g] !== 1'b1) cs_after_done[g]++;
      end
      if (n == stall_from) ready = 1'b0;
      if (n == stall_to) ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      total_cnt++;
      if (cs_n[g] !== 1'b1) $display("FAIL reset_cs_n[%0d]: got %b want 1", g, cs_n[g]);
      else pass_cnt++;
      total_cnt++;
      if (sck[g] !== 1'b0) $display("FAIL reset_sck[%0d]: got %b want 0", g, sck[g]);
      else pass_cnt++;
      total_cnt++;
      if (mosi[g] !== 1'b0) $display("FAIL reset_mosi[%0d]: got %b want 0", g, mosi[g]);
      else pass_cnt++;
      total_cnt++;
      if (wr_en[g] !== 1'b0) $display("FAIL reset_wr_en[%0d]: got %b want 0", g, wr_en[g]);
      else pass_cnt++;
      total_cnt++;
      if (wr_addr[g] !== 19'h0) $display("FAIL reset_wr_addr[%0d]: got %h want 0", g, wr_addr[g]);
      else pass_cnt++;
      total_cnt++;
      if (wr_data[g] !== 8'h0) $display("FAIL reset_wr_data[%0d]: got %h want 0", g, wr_data[g]);
      else pass_cnt++;
      total_cnt++;
      if (cpu_reset[g] !== 1'b1) $display("FAIL reset_cpu[%0d]: got %b want 1", g, cpu_reset[g]);
      else pass_cnt++;
      total_cnt++;
      if (done[g] !== 1'b0) $display("FAIL reset_done[%0d]: got %b want 0", g, done[g]);
      else pass_cnt++;
    end
  endtask

  task automatic test_copy();
    logic [7:0] exp_data [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    int snap;
    do_reset();
    snap = g_dut[0].cmd_cnt;
    run_capture(140, 0, 0);
    total_cnt++;
    if (g_dut[0].cmd_cnt - snap !== 1) $display("FAIL copy_cmd_count: got %0d want 1", g_dut[0].cmd_cnt - snap);
    else pass_cnt++;
    total_cnt++;
    if (g_dut[0].cmd_last !== 32'h03000000) $display("FAIL copy_mosi: got %h want 03000000", g_dut[0].cmd_last);
    else pass_cnt++;
    total_cnt++;
    if (cap_n[0] !== 4) $display("FAIL copy_pulses: got %0d want 4", cap_n[0]);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (cap_cyc[0][k] !== 81 + 17 * k) $display("FAIL copy_cycle[%0d]: got %0d want %0d", k, cap_cyc[0][k], 81 + 17 * k);
      else pass_cnt++;
      total_cnt++;
      if (cap_data[0][k] !== exp_data[k]) $display("FAIL copy_data[%0d]: got %h want %h", k, cap_data[0][k], exp_data[k]);
      else pass_cnt++;
      total_cnt++;
      if (cap_addr[0][k] !== 19'h7FF00 + 19'(k)) $display("FAIL copy_addr[%0d]: got %h want %h", k, cap_addr[0][k], 19'h7FF00 + 19'(k));
      else pass_cnt++;
      total_cnt++;
      if (cap_len[0][k] !== 1) $display("FAIL copy_len[%0d]: got %0d want 1", k, cap_len[0][k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_cyc[0] !== 133) $display("FAIL copy_done_cycle: got %0d want 133", done_cyc[0]);
    else pass_cnt++;
    total_cnt++;
    if (cpu_at_done[0] !== 1'b0) $display("FAIL copy_cpu_release: got %b want 0", cpu_at_done[0]);
    else pass_cnt++;
    total_cnt++;
    if (cs_at_done[0] !== 1'b1) $display("FAIL copy_cs_at_done: got %b want 1", cs_at_done[0]);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    logic [7:0] exp_data [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    int exp_cyc [4] = '{81, 98, 125, 142};
    int exp_len [4] = '{1, 11, 1, 1};
    do_reset();
    run_capture(160, 98, 108);
    total_cnt++;
    if (cap_n[0] !== 4) $display("FAIL stall_pulses: got %0d want 4", cap_n[0]);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (cap_cyc[0][k] !== exp_cyc[k]) $display("FAIL stall_cycle[%0d]: got %0d want %0d", k, cap_cyc[0][k], exp_cyc[k]);
      else pass_cnt++;
      total_cnt++;
      if (cap_len[0][k] !== exp_len[k]) $display("FAIL stall_len[%0d]: got %0d want %0d", k, cap_len[0][k], exp_len[k]);
      else pass_cnt++;
      total_cnt++;
      if (cap_data[0][k] !== exp_data[k]) $display("FAIL stall_data[%0d]: got %h want %h", k, cap_data[0][k], exp_data[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (cap_addr[0][1] !== 19'h7FF01) $display("FAIL stall_addr: got %h want 7ff01", cap_addr[0][1]);
    else pass_cnt++;
    total_cnt++;
    if (sck_wr[0] !== 0) $display("FAIL stall_sck_high: got %0d want 0", sck_wr[0]);
    else pass_cnt++;
    total_cnt++;
    if (unstable[0] !== 0) $display("FAIL stall_stability: got %0d want 0", unstable[0]);
    else pass_cnt++;
    total_cnt++;
    if (done_cyc[0] !== 143) $display("FAIL stall_done_cycle: got %0d want 143", done_cyc[0]);
    else pass_cnt++;
  endtask

  task automatic test_dest_wrap();
    logic [18:0] exp_addr [4] = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001};
    logic [7:0]  exp_data [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    do_reset();
    run_capture(140, 0, 0);
    total_cnt++;
    if (cap_n[1] !== 4) $display("FAIL wrap_pulses: got %0d want 4", cap_n[1]);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (cap_addr[1][k] !== exp_addr[k]) $display("FAIL wrap_addr[%0d]: got %h want %h", k, cap_addr[1][k], exp_addr[k]);
      else pass_cnt++;
      total_cnt++;
      if (cap_data[1][k] !== exp_data[k]) $display("FAIL wrap_data[%0d]: got %h want %h", k, cap_data[1][k], exp_data[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_cyc[1] !== 133) $display("FAIL wrap_done_cycle: got %0d want 133", done_cyc[1]);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int snap;
    do_reset();
    run_capture(106, 0, 0);
    total_cnt++;
    if (cap_n[0] !== 2) $display("FAIL midrst_pre_pulses: got %0d want 2", cap_n[0]);
    else pass_cnt++;
    total_cnt++;
    if (sck[0] !== 1'b1) $display("FAIL midrst_pre_sck: got %b want 1", sck[0]);
    else pass_cnt++;
    snap = g_dut[0].cmd_cnt;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (cs_n[0] !== 1'b1) $display("FAIL midrst_cs_n: got %b want 1", cs_n[0]);
    else pass_cnt++;
    total_cnt++;
    if (sck[0] !== 1'b0) $display("FAIL midrst_sck: got %b want 0", sck[0]);
    else pass_cnt++;
    total_cnt++;
    if (cpu_reset[0] !== 1'b1) $display("FAIL midrst_cpu: got %b want 1", cpu_reset[0]);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_capture(140, 0, 0);
    total_cnt++;
    if (g_dut[0].cmd_cnt - snap !== 1) $display("FAIL midrst_resend: got %0d want 1", g_dut[0].cmd_cnt - snap);
    else pass_cnt++;
    total_cnt++;
    if (g_dut[0].cmd_last !== 32'h03000000) $display("FAIL midrst_mosi: got %h want 03000000", g_dut[0].cmd_last);
    else pass_cnt++;
    total_cnt++;
    if (cap_cyc[0][0] !== 81) $display("FAIL midrst_first_cycle: got %0d want 81", cap_cyc[0][0]);
    else pass_cnt++;
    total_cnt++;
    if (cap_data[0][0] !== 8'hA5 || cap_addr[0][0] !== 19'h7FF00)
      $display("FAIL midrst_first_byte: got %h@%h want a5@7ff00", cap_data[0][0], cap_addr[0][0]);
    else pass_cnt++;
    total_cnt++;
    if (cap_n[0] !== 4) $display("FAIL midrst_pulses: got %0d want 4", cap_n[0]);
    else pass_cnt++;
  endtask

  task automatic test_single_byte();
    do_reset();
    run_capture(1100, 0, 0);
    total_cnt++;
    if (g_dut[2].cmd_last !== 32'h03012345) $display("FAIL single_mosi: got %h want 03012345", g_dut[2].cmd_last);
    else pass_cnt++;
    total_cnt++;
    if (cap_n[2] !== 1) $display("FAIL single_pulses: got %0d want 1", cap_n[2]);
    else pass_cnt++;
    total_cnt++;
    if (cap_cyc[2][0] !== 81) $display("FAIL single_cycle: got %0d want 81", cap_cyc[2][0]);
    else pass_cnt++;
    total_cnt++;
    if (cap_data[2][0] !== 8'h5A || cap_addr[2][0] !== 19'h7FF00)
      $display("FAIL single_byte: got %h@%h want 5a@7ff00", cap_data[2][0], cap_addr[2][0]);
    else pass_cnt++;
    total_cnt++;
    if (done_cyc[2] !== 82) $display("FAIL single_done_cycle: got %0d want 82", done_cyc[2]);
    else pass_cnt++;
    total_cnt++;
    if (cpu_at_done[2] !== 1'b0) $display("FAIL single_cpu_release: got %b want 0", cpu_at_done[2]);
    else pass_cnt++;
    total_cnt++;
    if (cs_after_done[2] !== 0) $display("FAIL single_cs_hold: got %0d low cycles want 0", cs_after_done[2]);
    else pass_cnt++;
    total_cnt++;
    if (done[2] !== 1'b1) $display("FAIL single_done_sticky: got %b want 1", done[2]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_copy();
    test_stall();
    test_dest_wrap();
    test_mid_reset();
    test_single_byte();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
